nibble_serial_addsub: RTL and testbench

NIBBLE_SERIAL_ADDSUB -- requirements
Module: nibble_serial_addsub

---
 rtl/nibble_addsub_pkg.sv | 21 ++
 rtl/nibble_serial_addsub_cla4.sv | 42 ++++
 rtl/nibble_serial_addsub.sv | 128 ++++++++++++
 tb/tb_nibble_serial_addsub.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_addsub_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor.
//   NIB_W      : width of one arithmetic slice (bits)
//   state_t    : control FSM encoding (IDLE / RUN / DONE)
//   idx_width(): width of the nibble index for a given nibble count
package nibble_addsub_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The index counts 0..nibbles-1. A single-nibble build still needs
    // one bit so that the index register has a legal width.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_addsub_cla4.sv
// 4-bit carry-lookahead slice, purely combinational.
//   a, b  : 4-bit operand nibbles
//   cin   : carry into bit 0
//   s     : 4-bit sum nibble
//   cout  : carry out of bit 3
//   grp_p : group propagate (all four bits propagate)
//   grp_g : group generate (the slice produces a carry by itself)
// Every carry is written directly in terms of generate/propagate and
// cin, so no carry depends on another carry.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       grp_p,
    output logic       grp_g
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign grp_p = &p;
    assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);

    assign c[4] = grp_g | (grp_p & cin);
    assign cout = c[4];

    assign s = p ^ c[3:0];

endmodule

// File: rtl/nibble_serial_addsub.sv
// Nibble-serial add/subtract with valid/ready handshakes on both sides.
// One 4-bit lookahead slice is reused across NIBBLES cycles.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   a, b, sub           : operands; sub=1 computes a-b
//   out_valid/out_ready : result handshake (valid only in DONE)
//   sum, cout, ovf, zero: result, carry (1 = no borrow on subtract),
//                         signed overflow, sum==0
module nibble_serial_addsub
    import nibble_addsub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NIB_W*NIBBLES-1:0] a,
    input  logic [NIB_W*NIBBLES-1:0] b,
    input  logic                     sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NIB_W*NIBBLES-1:0] sum,
    output logic                     cout,
    output logic                     ovf,
    output logic                     zero
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;      // already inverted for subtract
    logic [W-1:0]     sum_next;
    logic             last_nib;

    logic [NIB_W-1:0] slice_s;
    logic             slice_cout;
    logic             slice_p;
    logic             slice_g;

    cla4_slice u_slice (
        .a     (a_q[idx*NIB_W +: NIB_W]),
        .b     (b_q[idx*NIB_W +: NIB_W]),
        .cin   (carry),
        .s     (slice_s),
        .cout  (slice_cout),
        .grp_p (slice_p),
        .grp_g (slice_g)
    );

    // Handshake outputs are pure state decodes, so neither in_valid nor
    // out_ready can reach the opposite handshake combinationally.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last_nib  = (idx == LAST_IDX);

    // NOTE: NB assignments in clocked blocks so every register samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: defaults assigned first so every path drives every output;
    // a missing branch would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_nib)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        sum_next                        = sum;
        sum_next[idx*NIB_W +: NIB_W]    = slice_s;
    end

    // NOTE: the operand registers are never observed before being loaded,
    // but they are reset anyway so that simulation never carries X into
    // the slice and an aborted operation leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= sub ? ~b : b;
                        carry <= sub;     // the +1 of two's-complement negate
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum   <= sum_next;
                    // Nibble-level lookahead from the slice's group terms.
                    carry <= slice_g | (slice_p & carry);
                    if (last_nib) begin
                        cout <= slice_cout;
                        ovf  <= (a_q[W-1] == b_q[W-1]) &&
                                (sum_next[W-1] != a_q[W-1]);
                        zero <= (sum_next == '0);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;  // DONE holds the result until the handshake
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
module tb_nibble_serial_addsub;

    localparam int N = 4;
    localparam int W = 4 * N;
    localparam int LAT_LIMIT = 20;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    nibble_serial_addsub #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Reference: plain full-width arithmetic, borrow judged by magnitude.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s);
        exp_t         e;
        logic [W:0]   full;
        full = {1'b0, x} + {1'b0, y};
        if (s) begin
            e.sum  = x - y;
            e.cout = (x >= y);
            e.ovf  = (x[W-1] != y[W-1]) && (e.sum[W-1] != x[W-1]);
        end else begin
            e.sum  = full[W-1:0];
            e.cout = full[W];
            e.ovf  = (x[W-1] == y[W-1]) && (e.sum[W-1] != x[W-1]);
        end
        e.zero = (e.sum == '0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Offer an operand set at a negedge; returns #1 after the accepting edge.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        @(negedge clk);
        a = x; b = y; sub = s; in_valid = 1'b1;
        check("accept_in_ready", 32'(in_ready), 32'd1);
        q.push_back(model(x, y, s));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Count edges after the accept until out_valid; ends at a negedge.
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < LAT_LIMIT) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        if (!out_valid) check("timeout_out_valid", 32'd0, 32'd1);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            check({tag, "_sum"},  32'(sum),  32'(e.sum));
            check({tag, "_cout"}, 32'(cout), 32'(e.cout));
            check({tag, "_ovf"},  32'(ovf),  32'(e.ovf));
            check({tag, "_zero"}, 32'(zero), 32'(e.zero));
        end
    endtask

    // Compare at a negedge with out_valid high, then complete the handshake.
    task automatic finish_op(input string tag);
        pop_cmp(tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        int   lat;
        int   t;
        int   seen;
        int   t_first;
        logic [W-1:0] held;

        // Reset state, while asserted and after release.
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_flags",     {29'd0, cout, ovf, zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready",  32'(in_ready),  32'd1);
        check("rel_out_valid", 32'(out_valid), 32'd0);

        // Plain add, latency exactly N.
        start_op(16'h1234, 16'h4321, 1'b0);
        wait_done(lat);
        check("add1_latency", 32'(lat), 32'(N));
        check("add1_sum_lit", 32'(sum), 32'h5555);
        finish_op("add1");

        // Carry through every nibble.
        start_op(16'hFFFF, 16'h0001, 1'b0);
        wait_done(lat);
        check("add2_zero_lit", {30'd0, cout, zero}, 32'b11);
        finish_op("add2");

        // Subtract with signed overflow, then with borrow.
        start_op(16'h8000, 16'h0001, 1'b1);
        wait_done(lat);
        check("sub1_lit", {sum, 14'd0, cout, ovf}, {16'h7FFF, 14'd0, 2'b11});
        finish_op("sub1");

        start_op(16'h0000, 16'h0001, 1'b1);
        wait_done(lat);
        check("sub2_lit", {sum, 14'd0, cout, ovf}, {16'hFFFF, 14'd0, 2'b00});
        finish_op("sub2");

        // Back-pressure in DONE while new operands are offered.
        start_op(16'h0F0F, 16'h00F1, 1'b0);
        wait_done(lat);
        held = sum;
        a = 16'h0102; b = 16'h0304; sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready",  32'(in_ready),  32'd0);
            check("stall_sum",       32'(sum),       32'(held));
        end
        finish_op("stall");
        @(negedge clk);
        check("post_hs_in_ready",  32'(in_ready),  32'd1);
        check("post_hs_out_valid", 32'(out_valid), 32'd0);
        q.push_back(model(16'h0102, 16'h0304, 1'b0));
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_done(lat);
        check("stall_next_latency", 32'(lat), 32'(N));
        finish_op("stall_next");

        // Reset in RUN at idx 2 aborts the operation.
        start_op(16'h1234, 16'h1111, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready",  32'(in_ready),  32'd1);
        check("abort_sum",       32'(sum),       32'd0);
        check("abort_flags",     {29'd0, cout, ovf, zero}, 32'd0);
        void'(q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_idle_out_valid", 32'(out_valid), 32'd0);
        start_op(16'h0005, 16'h0003, 1'b0);
        wait_done(lat);
        check("after_abort_lit", 32'(sum), 32'h0008);
        finish_op("after_abort");

        // Operands change on the cycle after accept.
        start_op(16'h1111, 16'h2222, 1'b0);
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1;
        wait_done(lat);
        check("late_change_lit", 32'(sum), 32'h3333);
        finish_op("late_change");

        // Back-to-back throughput with both sides always willing.
        a = 16'h0101; b = 16'h0202; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        t = 0; seen = 0; t_first = 0;
        while (seen < 2 && t < 40) begin
            @(negedge clk);
            if (in_ready) q.push_back(model(16'h0101, 16'h0202, 1'b0));
            if (out_valid) begin
                pop_cmp("b2b");
                seen++;
                if (seen == 1) t_first = t;
                else check("b2b_interval", 32'(t - t_first), 32'(N + 2));
            end
            if (seen < 2) @(posedge clk);
            t++;
        end
        if (seen < 2) check("b2b_timeout", 32'(seen), 32'd2);
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("final_idle", 32'(in_ready), 32'd1);
        check("sb_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
